// File: rtl/dna_ser_receiver.sv
`default_nettype none
// ============================================================================
// Module   : dna_ser_receiver
// Purpose  : Receive end of the serial device-DNA stream. Reassembles an
//            LSB-first 1-bit data/valid stream into a DNA_BITS-wide word,
//            checks the frame length and compares the word against an
//            expected value. Reports sticky status to shell control logic.
// Ports    : clk, rst (sync, active-high)
//            arm                  - pulse: clear status, wait for new frame
//            ser_devDNA_in/_valid - serial bit and qualifier (one run = frame)
//            expected_DNA         - reference word, stable while busy
//            dev_DNA              - last successfully received word
//            dna_done, dna_match, err_short, err_long, err_timeout - sticky
//            busy                 - high in WAIT, RECV and DRAIN
//            good_frame_count     - successful captures, saturates at 255
// Revision : 1.0 - initial release
// ============================================================================
module dna_ser_receiver #(
  parameter int DNA_BITS       = 96,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                ser_devDNA_in,
  input  logic                ser_devDNA_in_valid,
  input  logic [DNA_BITS-1:0] expected_DNA,
  output logic [DNA_BITS-1:0] dev_DNA,
  output logic                dna_done,
  output logic                dna_match,
  output logic                err_short,
  output logic                err_long,
  output logic                err_timeout,
  output logic                busy,
  output logic [7:0]          good_frame_count
);

  // Timer is wide enough to hold TIMEOUT_CYCLES so it can saturate past it.
  localparam int c_tmr_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]   c_full_cnt = CNT_W'(DNA_BITS);
  localparam logic [c_tmr_w-1:0] c_tmr_last =
      c_tmr_w'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [c_tmr_w-1:0] c_tmr_max  = {c_tmr_w{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_RECV  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q,  state_d;
  logic [DNA_BITS-1:0] shreg_q,  shreg_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [c_tmr_w-1:0]  tmr_q,    tmr_d;
  logic                vld_dly_q, vld_dly_d;
  logic [DNA_BITS-1:0] dev_q,    dev_d;
  logic                done_q,   done_d;
  logic                match_q,  match_d;
  logic                short_q,  short_d;
  logic                long_q,   long_d;
  logic                tmo_q,    tmo_d;
  logic                busy_q,   busy_d;
  logic [7:0]          gcnt_q,   gcnt_d;
  logic                w_timeout_hit;
  logic                w_vld;

  assign w_vld = ser_devDNA_in_valid;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    vld_dly_d = w_vld;
    dev_d     = dev_q;
    done_d    = done_q;
    match_d   = match_q;
    short_d   = short_q;
    long_d    = long_q;
    tmo_d     = tmo_q;
    gcnt_d    = gcnt_q;
    w_timeout_hit = (TIMEOUT_CYCLES > 0) &&
                    ((state_q == S_WAIT) || (state_q == S_RECV)) &&
                    (tmr_q == c_tmr_last);

    if (arm) begin
      // Any stream bit present in the arm cycle is dropped here.
      state_d = S_WAIT;
      cnt_d   = '0;
      tmr_d   = '0;
      done_d  = 1'b0;
      match_d = 1'b0;
      short_d = 1'b0;
      long_d  = 1'b0;
      tmo_d   = 1'b0;
    end else begin
      if (((state_q == S_WAIT) || (state_q == S_RECV)) && (tmr_q != c_tmr_max)) begin
        tmr_d = tmr_q + 1'b1;
      end
      case (state_q)
        S_WAIT: begin
          if (w_timeout_hit) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
          end else if (w_vld && !vld_dly_q) begin
            // Rising edge only: the tail of a frame in flight at arm is skipped.
            shreg_d = {ser_devDNA_in, shreg_q[DNA_BITS-1:1]};
            cnt_d   = CNT_W'(1);
            state_d = S_RECV;
          end
        end
        S_RECV: begin
          if (!w_vld && (cnt_q == c_full_cnt)) begin
            // Completion outranks a timeout landing in the same cycle.
            dev_d   = shreg_q;
            done_d  = 1'b1;
            match_d = (shreg_q == expected_DNA);
            if (gcnt_q != 8'hFF) gcnt_d = gcnt_q + 8'd1;
            state_d = S_DONE;
          end else if (w_timeout_hit) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
          end else if (w_vld && (cnt_q == c_full_cnt)) begin
            long_d  = 1'b1;
            state_d = S_DRAIN;
          end else if (w_vld) begin
            shreg_d = {ser_devDNA_in, shreg_q[DNA_BITS-1:1]};
            cnt_d   = cnt_q + 1'b1;
          end else begin
            short_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_DRAIN: begin
          if (!w_vld) state_d = S_IDLE;
        end
        default: ;
      endcase
    end

    busy_d = (state_d == S_WAIT) || (state_d == S_RECV) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      vld_dly_q <= 1'b0;
      dev_q     <= '0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      tmo_q     <= 1'b0;
      busy_q    <= 1'b0;
      gcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      vld_dly_q <= vld_dly_d;
      dev_q     <= dev_d;
      done_q    <= done_d;
      match_q   <= match_d;
      short_q   <= short_d;
      long_q    <= long_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      gcnt_q    <= gcnt_d;
    end
  end

  assign dev_DNA          = dev_q;
  assign dna_done         = done_q;
  assign dna_match        = match_q;
  assign err_short        = short_q;
  assign err_long         = long_q;
  assign err_timeout      = tmo_q;
  assign busy             = busy_q;
  assign good_frame_count = gcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dna_ser_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_dna_ser_receiver
// Purpose  : Self-checking bench for dna_ser_receiver. Three instances:
//            default parameters, a 16-cycle timeout variant, and an 8-bit
//            variant with timeout disabled for counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dna_ser_receiver;
  localparam int N = 96;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0, arm_t = 1'b0, arm_s = 1'b0;
  logic din = 1'b0, vld = 1'b0;
  logic [N-1:0] exp_dna = '0;
  logic [7:0]   exp_s = '0;

  logic [N-1:0] dev;   logic done, match, e_sh, e_lg, e_to, busy;     logic [7:0] gcnt;
  logic [N-1:0] dev_t; logic done_t, match_t, e_sh_t, e_lg_t, e_to_t, busy_t; logic [7:0] gcnt_t;
  logic [7:0]   dev_s; logic done_s, match_s, e_sh_s, e_lg_s, e_to_s, busy_s; logic [7:0] gcnt_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] m_dev;   // model: last good word
  int           m_cnt;   // model: good frame count

  always #5 clk = ~clk;

  dna_ser_receiver dut (
    .clk(clk), .rst(rst), .arm(arm), .ser_devDNA_in(din), .ser_devDNA_in_valid(vld),
    .expected_DNA(exp_dna), .dev_DNA(dev), .dna_done(done), .dna_match(match),
    .err_short(e_sh), .err_long(e_lg), .err_timeout(e_to), .busy(busy),
    .good_frame_count(gcnt));

  dna_ser_receiver #(.DNA_BITS(96), .TIMEOUT_CYCLES(16), .CNT_W(7)) dut_t (
    .clk(clk), .rst(rst), .arm(arm_t), .ser_devDNA_in(din), .ser_devDNA_in_valid(vld),
    .expected_DNA(exp_dna), .dev_DNA(dev_t), .dna_done(done_t), .dna_match(match_t),
    .err_short(e_sh_t), .err_long(e_lg_t), .err_timeout(e_to_t), .busy(busy_t),
    .good_frame_count(gcnt_t));

  dna_ser_receiver #(.DNA_BITS(8), .TIMEOUT_CYCLES(0), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .arm(arm_s), .ser_devDNA_in(din), .ser_devDNA_in_valid(vld),
    .expected_DNA(exp_s), .dev_DNA(dev_s), .dna_done(done_s), .dna_match(match_s),
    .err_short(e_sh_s), .err_long(e_lg_s), .err_timeout(e_to_s), .busy(busy_s),
    .good_frame_count(gcnt_s));

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  function automatic logic [N-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Drive n contiguous valid bits of w, LSB first; bits past N are random.
  task automatic drive_bits(input logic [N-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      din = (i < N) ? w[i] : 1'($urandom());
      vld = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; tick(); tick();
    n_checks++; if (dev !== '0) begin n_fail++; $display("FAIL reset_dev: got %h want 0", dev); end
    n_checks++; if ({done, match, e_sh, e_lg, e_to, busy} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 000000", {done, match, e_sh, e_lg, e_to, busy}); end
    n_checks++; if (gcnt !== 8'd0) begin n_fail++; $display("FAIL reset_gcnt: got %0d want 0", gcnt); end
    rst = 1'b0; tick();
    m_dev = '0; m_cnt = 0;
  endtask

  task automatic test_match();
    logic [N-1:0] w;
    w = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
    exp_dna = w;
    pulse_arm();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL match_busy_wait: got %b want 1", busy); end
    drive_bits(w, N);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL match_done_early: got %b want 0", done); end
    vld = 1'b0; tick();
    m_dev = w; m_cnt++;
    n_checks++; if ({done, match} !== 2'b11) begin n_fail++; $display("FAIL match_flags: got %b want 11", {done, match}); end
    n_checks++; if (dev !== m_dev) begin n_fail++; $display("FAIL match_dev: got %h want %h", dev, m_dev); end
    n_checks++; if (gcnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL match_gcnt: got %0d want %0d", gcnt, m_cnt); end
    n_checks++; if ({e_sh, e_lg, e_to, busy} !== 4'b0) begin n_fail++; $display("FAIL match_errs: got %b want 0000", {e_sh, e_lg, e_to, busy}); end
  endtask

  task automatic test_mismatch();
    logic [N-1:0] w;
    w = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
    exp_dna = w ^ (96'h1 << 95);
    tick(); pulse_arm();
    drive_bits(w, N);
    vld = 1'b0; tick();
    m_dev = w; m_cnt++;
    n_checks++; if ({done, match} !== 2'b10) begin n_fail++; $display("FAIL mismatch_flags: got %b want 10", {done, match}); end
    n_checks++; if (dev !== m_dev) begin n_fail++; $display("FAIL mismatch_dev: got %h want %h", dev, m_dev); end
  endtask

  task automatic test_short();
    tick(); pulse_arm();
    drive_bits(rand_word(), N - 1);
    vld = 1'b0; tick();
    n_checks++; if ({e_sh, done, busy} !== 3'b100) begin n_fail++; $display("FAIL short_flags: got %b want 100", {e_sh, done, busy}); end
    n_checks++; if (dev !== m_dev) begin n_fail++; $display("FAIL short_dev: got %h want %h", dev, m_dev); end
  endtask

  task automatic test_long();
    tick(); pulse_arm();
    drive_bits(rand_word(), N);
    n_checks++; if (e_lg !== 1'b0) begin n_fail++; $display("FAIL long_early: got %b want 0", e_lg); end
    drive_bits(rand_word(), 1);
    n_checks++; if ({e_lg, busy} !== 2'b11) begin n_fail++; $display("FAIL long_flag: got %b want 11", {e_lg, busy}); end
    drive_bits(rand_word(), 3);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL long_drain_busy: got %b want 1", busy); end
    vld = 1'b0; tick();
    n_checks++; if ({busy, done, e_lg} !== 3'b001) begin n_fail++; $display("FAIL long_end: got %b want 001", {busy, done, e_lg}); end
    n_checks++; if (dev !== m_dev) begin n_fail++; $display("FAIL long_dev: got %h want %h", dev, m_dev); end
  endtask

  task automatic test_timeout();
    vld = 1'b0; tick();
    arm_t = 1'b1; tick(); arm_t = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if ({e_to_t, busy_t} !== 2'b01) begin n_fail++; $display("FAIL timeout_early: got %b want 01", {e_to_t, busy_t}); end
    tick();
    n_checks++; if ({e_to_t, busy_t, done_t} !== 3'b100) begin n_fail++; $display("FAIL timeout_fire: got %b want 100", {e_to_t, busy_t, done_t}); end
  endtask

  task automatic test_arm_mid_frame();
    logic [N-1:0] w1, w2;
    w1 = rand_word(); w2 = rand_word();
    exp_dna = w2;
    tick(); pulse_arm();
    for (int i = 0; i < N; i++) begin
      din = w1[i]; vld = 1'b1; arm = (i == 39);
      tick();
    end
    arm = 1'b0; vld = 1'b0; tick();
    n_checks++; if ({e_sh, done, busy} !== 3'b001) begin n_fail++; $display("FAIL armmid_tail: got %b want 001", {e_sh, done, busy}); end
    drive_bits(w2, N);
    vld = 1'b0; tick();
    m_dev = w2; m_cnt++;
    n_checks++; if ({done, match, e_sh} !== 3'b110) begin n_fail++; $display("FAIL armmid_second: got %b want 110", {done, match, e_sh}); end
    n_checks++; if (dev !== m_dev) begin n_fail++; $display("FAIL armmid_dev: got %h want %h", dev, m_dev); end
  endtask

  // Random lengths around the boundary, random match/mismatch; outcome is
  // predicted from frame length alone.
  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [N-1:0] w;
      int n;
      bit want_match;
      w = rand_word();
      case ($urandom_range(3, 0))
        0: n = N - 1;
        1: n = N;
        2: n = N + 1 + int'($urandom_range(4, 0));
        default: n = int'($urandom_range(100, 1));
      endcase
      want_match = 1'($urandom());
      exp_dna = want_match ? w : (w ^ (96'h1 << $urandom_range(95, 0)));
      tick(); pulse_arm();
      drive_bits(w, n);
      vld = 1'b0; tick();
      if (n == N) begin
        m_dev = w; m_cnt++;
      end
      n_checks++;
      if ({done, match, e_sh, e_lg, busy} !== {n == N, (n == N) && want_match, n < N, n > N, 1'b0}) begin
        n_fail++;
        $display("FAIL random_flags n=%0d: got %b want %b", n, {done, match, e_sh, e_lg, busy},
                 {n == N, (n == N) && want_match, n < N, n > N, 1'b0});
      end
      n_checks++; if (dev !== m_dev) begin n_fail++; $display("FAIL random_dev n=%0d: got %h want %h", n, dev, m_dev); end
      n_checks++; if (gcnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL random_gcnt: got %0d want %0d", gcnt, m_cnt); end
    end
  endtask

  task automatic test_rst_mid_frame();
    logic [N-1:0] w;
    w = rand_word();
    exp_dna = w;
    tick(); pulse_arm();
    for (int i = 0; i < 50; i++) begin
      din = w[i]; vld = 1'b1; rst = (i == 49);
      tick();
    end
    m_dev = '0; m_cnt = 0;
    n_checks++; if ({dev, gcnt, done, match, e_sh, e_lg, e_to, busy} !== '0) begin n_fail++; $display("FAIL rstmid_outputs: dev=%h gcnt=%0d flags=%b want all 0", dev, gcnt, {done, match, e_sh, e_lg, e_to, busy}); end
    rst = 1'b0; vld = 1'b0; tick();
    pulse_arm();
    drive_bits(w, N);
    vld = 1'b0; tick();
    m_dev = w; m_cnt++;
    n_checks++; if ({done, match} !== 2'b11) begin n_fail++; $display("FAIL rstmid_capture: got %b want 11", {done, match}); end
    n_checks++; if (dev !== m_dev || gcnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL rstmid_dev: got %h/%0d want %h/%0d", dev, gcnt, m_dev, m_cnt); end
  endtask

  // 8-bit variant; timeout disabled, so long idle gaps never fire err_timeout.
  task automatic test_saturation();
    logic [7:0] b;
    b = '0;
    for (int k = 1; k <= 258; k++) begin
      b = 8'($urandom());
      exp_s = b;
      arm_s = 1'b1; tick(); arm_s = 1'b0;
      for (int i = 0; i < 8; i++) begin
        din = b[i]; vld = 1'b1; tick();
      end
      vld = 1'b0; tick();
      if (k == 255 || k == 258) begin
        n_checks++; if (gcnt_s !== 8'd255) begin n_fail++; $display("FAIL sat_gcnt k=%0d: got %0d want 255", k, gcnt_s); end
      end
    end
    n_checks++; if ({done_s, match_s, dev_s} !== {2'b11, b}) begin n_fail++; $display("FAIL sat_last: got %b/%h want 11/%h", {done_s, match_s}, dev_s, b); end
    arm_s = 1'b1; tick(); arm_s = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    n_checks++; if ({e_to_s, busy_s} !== 2'b01) begin n_fail++; $display("FAIL sat_no_timeout: got %b want 01", {e_to_s, busy_s}); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_short();
    test_long();
    test_timeout();
    test_arm_mid_frame();
    test_random();
    test_rst_mid_frame();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
